// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add sequencer for mul / mulh / mulhu in EX.
// Holds the pipeline via a combinational stall, then pulses done with the
// selected 32-bit half of the 64-bit product in result.
module mul_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      aluop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;
  logic [2*XLEN-1:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic                neg;
  logic                hi;

  logic                is_mul;
  logic                is_mulh;
  logic                accept;
  logic                last_iter;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic [2*XLEN-1:0]   prod;

  // Decode, accept condition, operand magnitudes and final signed product.
  always_comb begin
    is_mul    = (aluop == 4'b0101) || (aluop == 4'b0110) || (aluop == 4'b0111);
    is_mulh   = (aluop == 4'b0110);
    accept    = (state == IDLE) && start && is_mul && !done && !flush;
    last_iter = (cnt == CNT_W'(XLEN - 1));
    abs_a     = a[XLEN-1] ? (~a + 1'b1) : a;
    abs_b     = b[XLEN-1] ? (~b + 1'b1) : b;
    prod      = neg ? (~acc + 1'b1) : acc;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush aborts from any state, including FIN.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = RUN;
        RUN:     if (last_iter) state_next = FIN;
        FIN:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Stall output: busy or accepting now; never while flushing or in reset.
  always_comb begin
    stall = !rst && !flush && ((state != IDLE) || accept);
  end

  // Datapath: latch operands on accept, shift-add in RUN, publish in FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      result <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      hi     <= 1'b0;
    end else if (flush) begin
      done <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= {{XLEN{1'b0}}, (is_mulh ? abs_a : a)};
            mplier <= is_mulh ? abs_b : b;
            neg    <= is_mulh && (a[XLEN-1] ^ b[XLEN-1]);
            hi     <= (aluop != 4'b0101);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIN: begin
          result <= hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: randomized and directed checks of mul_sequencer against
// an arithmetic reference model of mul / mulh / mulhu.
module tb_mul_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int vectors;
  int miscompares;
  logic [31:0] last_res;

  mul_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .aluop  (aluop),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Reference: full-precision products via plain arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] up;
    longint      sp;
    logic [63:0] sv;
    up = {32'b0, x} * {32'b0, y};
    sp = longint'(signed'(x)) * longint'(signed'(y));
    sv = sp;
    case (op)
      4'b0101: return up[31:0];
      4'b0111: return up[63:32];
      default: return sv[63:32];
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'h1;
      2:       v = 32'h8000_0000;
      3:       v = 32'hFFFF_FFFF;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op (caller positioned just after a rising edge) and observe it
  // until done or a cycle budget expires. Operands scramble after acceptance.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit hold, output int sc, output int dc,
                        output logic [31:0] res, output bit stall_in_done);
    bit seen;
    start = 1'b1; aluop = op; a = x; b = y;
    sc = 0; dc = 0; res = '0; stall_in_done = 1'b0; seen = 1'b0;
    for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
      @(negedge clk);
      if (stall) sc++;
      if (done) begin
        dc++;
        res  = result;
        seen = 1'b1;
        if (stall) stall_in_done = 1'b1;
      end
      @(posedge clk); #1;
      if (!hold || seen) start = 1'b0;
      if (!seen) begin
        a = $urandom; b = $urandom;
        if (!hold) aluop = 4'($urandom);
      end
    end
  endtask

  task automatic idle_watch(input int n, output int dcount, output int scount);
    dcount = 0; scount = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (stall) scount++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input bit hold);
    int sc, dc; logic [31:0] res; bit sid; logic [31:0] exp;
    exp = model(op, x, y);
    run_op(op, x, y, hold, sc, dc, res, sid);
    vectors++;
    if (dc !== 1) begin
      miscompares++;
      $display("FAIL %s_done: got %0d done pulses, required 1", name, dc);
    end
    vectors++;
    if (res !== exp) begin
      miscompares++;
      $display("FAIL %s_result: op=%b a=%h b=%h got %h, required %h", name, op, x, y, res, exp);
    end
    vectors++;
    if (sc !== 34) begin
      miscompares++;
      $display("FAIL %s_stall_cycles: got %0d, required 34", name, sc);
    end
    vectors++;
    if (sid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_stall_in_done: got %b, required 0", name, sid);
    end
    last_res = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; aluop = 4'b0101; a = 32'd7; b = 32'd6; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({stall, done, result} !== 34'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: got stall=%b done=%b result=%h, required 0 0 0",
                 stall, done, result);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    last_res = '0;
  endtask

  task automatic test_directed();
    check_op("mul_7x6", 4'b0101, 32'd7, 32'd6, 1'b0);
    vectors++;
    if (last_res !== 32'h0000_002A) begin
      miscompares++;
      $display("FAIL mul_7x6_const: model gives %h, required 0000002a", last_res);
    end
    check_op("mulhu_ff", 4'b0111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_op("mulh_min", 4'b0110, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check_op("mulh_neg", 4'b0110, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    check_op("mulh_m1", 4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] op;
      op = 4'(5 + $urandom_range(0, 2));
      check_op("rand", op, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_flush();
    logic [31:0] prior;
    int dseen;
    prior = last_res;
    dseen = 0;
    start = 1'b1; aluop = 4'b0101; a = 32'd7; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (done) dseen++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stall: got %b, required 0", stall);
    end
    if (done) dseen++;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++;
    if (result !== prior) begin
      miscompares++;
      $display("FAIL flush_result_hold: got %h, required %h", result, prior);
    end
    vectors++;
    if (dseen !== 0) begin
      miscompares++;
      $display("FAIL flush_no_done: got %0d done pulses, required 0", dseen);
    end
    check_op("after_flush", 4'b0101, 32'd3, 32'd5, 1'b0);
  endtask

  task automatic test_back_to_back();
    int dc, sc;
    check_op("held_start", 4'b0110, pick_operand(), pick_operand(), 1'b1);
    check_op("b2b_2x9", 4'b0101, 32'd2, 32'd9, 1'b0);
    idle_watch(40, dc, sc);
    vectors++;
    if (dc !== 0) begin
      miscompares++;
      $display("FAIL b2b_extra_done: got %0d, required 0", dc);
    end
  endtask

  task automatic test_nonmul();
    for (int i = 0; i < 6; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      while (op inside {4'b0101, 4'b0110, 4'b0111}) op = 4'($urandom_range(0, 15));
      if (i == 0) op = 4'b0011;
      start = 1'b1; aluop = op; a = $urandom; b = $urandom;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vectors++;
        if (stall !== 1'b0 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL nonmul_%b: got stall=%b done=%b, required 0 0", op, stall, done);
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int dc, sc;
    start = 1'b1; aluop = 4'b0111; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_during_stall: got %b, required 0", stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall, done, result} !== 34'b0) begin
      miscompares++;
      $display("FAIL rst_midrun_outputs: got stall=%b done=%b result=%h, required 0 0 0",
               stall, done, result);
    end
    @(posedge clk); #1;
    idle_watch(40, dc, sc);
    vectors++;
    if (dc !== 0 || sc !== 0) begin
      miscompares++;
      $display("FAIL rst_midrun_quiet: got %0d done, %0d stall cycles, required 0 0", dc, sc);
    end
    last_res = '0;
    check_op("after_rst", 4'b0110, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; aluop = '0; a = '0; b = '0; flush = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_nonmul();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
